// File: rtl/pipeline_flow_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its flow controller.
// The datapath (master) raises stall/redirect/exception requests and the
// controller (slave) answers with per-stage hold and invalidate strobes.
interface pipeline_flow_ctrl_if #(
    parameter int STAGES = 5
);
    logic [STAGES-1:0] stall_req_i;
    logic              redirect_i;
    logic              excp_i;
    logic [STAGES-1:0] stall_o;
    logic [STAGES-1:0] flush_o;
    logic              pc_invalid_o;

    modport master (
        output stall_req_i, redirect_i, excp_i,
        input  stall_o, flush_o, pc_invalid_o
    );

    modport slave (
        input  stall_req_i, redirect_i, excp_i,
        output stall_o, flush_o, pc_invalid_o
    );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline hazard/flow controller: turns per-stage stall requests, branch
// redirects and exception commits into per-stage hold (stall) and
// invalidate (flush) strobes, with a small FSM that keeps killing wrong-path
// fetches after a redirect and fully flushes the pipe after an exception.
module pipeline_flow_ctrl #(
    parameter int STAGES      = 5,
    parameter int BR_STAGE    = 1,
    parameter int BR_SHADOW   = 1,
    parameter int EXCP_CYCLES = 2,
    parameter int PERF_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_flow_ctrl_if.slave   bus,
    output logic [1:0]            state_o,
    output logic [PERF_W-1:0]     perf_stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHADOW = 2'd1,
        ST_EXCP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_shadow_cnt;
    logic [2:0]        r_excp_cnt;
    logic [PERF_W-1:0] r_perf;

    logic [STAGES-1:0] w_stall_base;
    logic [STAGES-1:0] w_bubble;
    logic [STAGES-1:0] w_stall;
    logic [STAGES-1:0] w_flush;
    logic              w_pc_invalid;
    logic              w_excp_mode;
    logic              w_eff_redirect;

    // Combinational strobe generation: stall fan-in, bubbles, redirect and flush overlays.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_stall_base   = '0;
        w_bubble       = '0;
        w_stall        = '0;
        w_flush        = '0;
        w_pc_invalid   = 1'b0;

        // A stalled stage k forces every younger-indexed stage to hold too.
        for (int j = 0; j < STAGES; j++) begin
            w_stall_base[j] = |(bus.stall_req_i >> j);
        end
        // The stage just past the highest stalled one receives a bubble.
        for (int j = 1; j < STAGES; j++) begin
            w_bubble[j] = w_stall_base[j-1] & ~w_stall_base[j];
        end

        w_excp_mode    = bus.excp_i | (r_state == ST_EXCP);
        w_eff_redirect = bus.redirect_i & ~w_stall_base[BR_STAGE] & ~w_excp_mode;

        if (w_excp_mode) begin
            w_stall = '0;
            w_flush = '1;
        end else begin
            w_stall = w_stall_base;
            w_flush = w_bubble;
            if (w_eff_redirect) begin
                for (int j = 0; j < BR_STAGE; j++) begin
                    w_flush[j] = 1'b1;
                end
            end
            if (r_state == ST_SHADOW) begin
                w_flush[BR_STAGE-1] = 1'b1;
            end
        end
        w_pc_invalid = bus.excp_i | w_eff_redirect;

        // Outputs are quiet while reset is held, whatever the inputs do.
        if (!rst_n) begin
            w_stall      = '0;
            w_flush      = '0;
            w_pc_invalid = 1'b0;
        end
    end

    assign bus.stall_o      = w_stall;
    assign bus.flush_o      = w_flush;
    assign bus.pc_invalid_o = w_pc_invalid;

    // FSM: exception flush window, wrong-path shadow window, idle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: async reset clears state immediately; sequential state uses <= only.
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_shadow_cnt <= '0;
            r_excp_cnt   <= '0;
        end else if (bus.excp_i) begin
            r_state      <= ST_EXCP;
            r_excp_cnt   <= 3'(EXCP_CYCLES - 1);
            r_shadow_cnt <= '0;
        end else begin
            case (r_state)
                ST_EXCP: begin
                    if (r_excp_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_excp_cnt <= r_excp_cnt - 3'd1;
                    end
                end
                ST_SHADOW: begin
                    if (w_eff_redirect) begin
                        r_shadow_cnt <= 3'(BR_SHADOW);
                    end else if (!w_stall[BR_STAGE-1]) begin
                        if (r_shadow_cnt <= 3'd1) begin
                            r_state      <= ST_IDLE;
                            r_shadow_cnt <= '0;
                        end else begin
                            r_shadow_cnt <= r_shadow_cnt - 3'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_eff_redirect && BR_SHADOW > 0) begin
                        r_state      <= ST_SHADOW;
                        r_shadow_cnt <= 3'(BR_SHADOW);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_shadow_cnt <= '0;
                    r_excp_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which any stage is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (|w_stall && !(&r_perf)) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign state_o          = r_state;
    assign perf_stall_cnt_o = r_perf;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: a default-parameter instance plus a
// PERF_W=4 instance fed the same inputs to exercise counter saturation.
module tb_pipeline_flow_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_flow_ctrl_if #(.STAGES(5)) u_if ();
    pipeline_flow_ctrl_if #(.STAGES(5)) u_if4 ();

    logic [1:0]  state_o;
    logic [31:0] perf_o;
    logic [1:0]  state4_o;
    logic [3:0]  perf4_o;

    assign u_if4.stall_req_i = u_if.stall_req_i;
    assign u_if4.redirect_i  = u_if.redirect_i;
    assign u_if4.excp_i      = u_if.excp_i;

    pipeline_flow_ctrl u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (u_if.slave),
        .state_o          (state_o),
        .perf_stall_cnt_o (perf_o)
    );

    pipeline_flow_ctrl #(.PERF_W(4)) u_dut4 (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (u_if4.slave),
        .state_o          (state4_o),
        .perf_stall_cnt_o (perf4_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] sr, input logic rd, input logic ex);
        u_if.stall_req_i = sr;
        u_if.redirect_i  = rd;
        u_if.excp_i      = ex;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [4:0] st, input logic [4:0] fl, input logic pc);
        check({tag, ".stall"}, 32'(u_if.stall_o), 32'(st));
        check({tag, ".flush"}, 32'(u_if.flush_o), 32'(fl));
        check({tag, ".pc_inv"}, 32'(u_if.pc_invalid_o), 32'(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with every input asserted: outputs stay quiet.
        drive(5'b11111, 1'b1, 1'b1);
        #10;
        outs("rst", 5'b00000, 5'b00000, 1'b0);
        check("rst.state", 32'(state_o), 32'd0);
        check("rst.perf", perf_o, 32'd0);
        drive(5'b00000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Single redirect, no stalls.
        drive(5'b00000, 1'b1, 1'b0);
        outs("redir.N", 5'b00000, 5'b00001, 1'b1);
        check("redir.N.state", 32'(state_o), 32'd0);
        cycle();
        drive(5'b00000, 1'b0, 1'b0);
        outs("redir.N1", 5'b00000, 5'b00001, 1'b0);
        check("redir.N1.state", 32'(state_o), 32'd1);
        cycle();
        outs("redir.N2", 5'b00000, 5'b00000, 1'b0);
        check("redir.N2.state", 32'(state_o), 32'd0);

        // Mid-pipe stall with bubble insertion and perf counting.
        drive(5'b00100, 1'b0, 1'b0);
        outs("stall2", 5'b00111, 5'b01000, 1'b0);
        cycle();
        check("stall2.perf1", perf_o, 32'd1);
        cycle();
        check("stall2.perf2", perf_o, 32'd2);

        // Redirect on a stalled branch stage is ignored.
        drive(5'b00010, 1'b1, 1'b0);
        outs("redir_stalled", 5'b00011, 5'b00100, 1'b0);
        cycle();
        check("redir_stalled.state", 32'(state_o), 32'd0);
        check("redir_stalled.perf", perf_o, 32'd3);

        // Shadow held by stage-0 stall for 3 cycles, exits after one free cycle.
        drive(5'b00000, 1'b1, 1'b0);
        cycle();
        check("shadow.enter", 32'(state_o), 32'd1);
        drive(5'b00001, 1'b0, 1'b0);
        outs("shadow.stalled", 5'b00001, 5'b00011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("shadow.hold%0d", i), 32'(state_o), 32'd1);
        end
        check("shadow.perf", perf_o, 32'd6);
        drive(5'b00000, 1'b0, 1'b0);
        outs("shadow.free", 5'b00000, 5'b00001, 1'b0);
        cycle();
        check("shadow.exit", 32'(state_o), 32'd0);

        // Second redirect while in shadow reloads the counter.
        drive(5'b00000, 1'b1, 1'b0);
        cycle();
        check("reload.enter", 32'(state_o), 32'd1);
        outs("reload.redir", 5'b00000, 5'b00001, 1'b1);
        cycle();
        check("reload.held", 32'(state_o), 32'd1);
        drive(5'b00000, 1'b0, 1'b0);
        cycle();
        check("reload.exit", 32'(state_o), 32'd0);

        // Exception in shadow with full stall request: 3 flush cycles, then stalls resume.
        drive(5'b00000, 1'b1, 1'b0);
        cycle();
        check("excp.shadow", 32'(state_o), 32'd1);
        drive(5'b11111, 1'b0, 1'b1);
        outs("excp.trig", 5'b00000, 5'b11111, 1'b1);
        cycle();
        check("excp.st1", 32'(state_o), 32'd2);
        drive(5'b11111, 1'b1, 1'b0);
        outs("excp.c1", 5'b00000, 5'b11111, 1'b0);
        cycle();
        check("excp.st2", 32'(state_o), 32'd2);
        drive(5'b11111, 1'b0, 1'b0);
        outs("excp.c2", 5'b00000, 5'b11111, 1'b0);
        cycle();
        check("excp.done", 32'(state_o), 32'd0);
        outs("excp.resume", 5'b11111, 5'b00000, 1'b0);
        cycle();
        check("excp.perf", perf_o, 32'd7);

        // Saturation of the 4-bit counter after a fresh reset.
        drive(5'b00000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("sat.rst_perf4", 32'(perf4_o), 32'd0);
        rst_n = 1'b1;
        cycle();
        drive(5'b00001, 1'b0, 1'b0);
        repeat (14) cycle();
        check("sat.perf4_14", 32'(perf4_o), 32'd14);
        repeat (3) cycle();
        check("sat.perf4_sat", 32'(perf4_o), 32'd15);
        check("sat.perf32", perf_o, 32'd17);

        // Reset asserted in the middle of an exception window.
        drive(5'b00000, 1'b0, 1'b1);
        cycle();
        drive(5'b11111, 1'b1, 1'b0);
        check("mid.excp_state", 32'(state_o), 32'd2);
        rst_n = 1'b0;
        #1;
        outs("mid.rst", 5'b00000, 5'b00000, 1'b0);
        check("mid.rst_state", 32'(state_o), 32'd0);
        check("mid.rst_perf", perf_o, 32'd0);
        cycle();
        drive(5'b00000, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle();
        outs("mid.after", 5'b00000, 5'b00000, 1'b0);
        check("mid.after_state", 32'(state_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_flow_ctrl.md
PIPELINE_FLOW_CTRL -- requirements
Module: pipeline_flow_ctrl

Interface
REQ-001 Parameter STAGES, default 5, pipeline stage count; stage 0 = PC/IF, STAGES-1 = WB; legal range 2..8.
REQ-002 Parameter BR_STAGE, default 1, stage index resolving branches; legal range 1..STAGES-1.
REQ-003 Parameter BR_SHADOW, default 1, wrong-path cycles invalidated after a redirect; legal range 0..7.
REQ-004 Parameter EXCP_CYCLES, default 2, cycles of full flush per exception; legal range 1..7.
REQ-005 Parameter PERF_W, default 32, stall performance counter width.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 stall_req_i  input  STAGES  bit i = stage i cannot advance this cycle.
REQ-009 redirect_i  input  1  branch at BR_STAGE redirects the PC this cycle.
REQ-010 excp_i  input  1  exception/ertn commit; flush entire pipeline.
REQ-011 stall_o  output  STAGES  bit i = stage i holds its output register.
REQ-012 flush_o  output  STAGES  bit i = stage i output register loaded invalid next edge.
REQ-013 pc_invalid_o  output  1  current PC fetch is wrong-path; PC must take redirect target.
REQ-014 state_o  output  2  FSM state: 0 IDLE, 1 SHADOW, 2 EXCP.
REQ-015 perf_stall_cnt_o  output  PERF_W  count of cycles with any stall_o bit set.

Function
REQ-016 Stall: k = highest index with stall_req_i[k]=1; stall_o[j]=1 for all j<=k, 0 above; if k<STAGES-1, flush_o[k+1]=1 (bubble insert).
REQ-017 stall_o/flush_o/pc_invalid_o combinational from inputs and registered state; zero added latency.
REQ-018 Effective redirect = redirect_i & ~stall_o[BR_STAGE] & ~excp_i & (state!=EXCP); a redirect on a stalled branch stage is ignored (upstream re-presents it).
REQ-019 Effective redirect cycle: flush_o[BR_STAGE-1:0] all 1, pc_invalid_o=1.
REQ-020 Effective redirect with BR_SHADOW>0: next state SHADOW, shadow counter loaded BR_SHADOW; with BR_SHADOW=0: state unchanged (IDLE).
REQ-021 SHADOW: flush_o[BR_STAGE-1]=1 every cycle; counter decrements only when stall_o[BR_STAGE-1]=0; counter==1 with no stall -> IDLE.
REQ-022 Effective redirect while in SHADOW reloads counter to BR_SHADOW (no accumulation, no early exit).
REQ-023 excp_i=1 in any state: flush_o all 1, stall_o all 0, pc_invalid_o=1; next state EXCP, excp counter loaded EXCP_CYCLES-1, shadow counter cleared.
REQ-024 EXCP: flush_o all 1, stall_o all 0, stall_req_i and redirect_i ignored; counter==0 -> IDLE else decrement; excp_i in EXCP reloads counter.
REQ-025 Priority: excp_i/EXCP > effective redirect/SHADOW > stall; flush_o is bitwise OR of all active sources; stall_o and flush_o may both be 1 on one bit (register held and marked invalid).
REQ-026 perf_stall_cnt_o increments by 1 on each edge where |stall_o=1; saturates at all-ones, no wrap.
REQ-027 Illegal state encoding 3 -> IDLE next edge, outputs as IDLE.

Reset
REQ-028 rst_n low: state IDLE, both counters 0, perf_stall_cnt_o 0, immediately and asynchronously.
REQ-029 Under reset, stall_o, flush_o, pc_invalid_o = 0 regardless of inputs; first evaluation on the edge after rst_n deassertion.
REQ-030 Reset mid-SHADOW or mid-EXCP abandons the sequence; no residual flush after release.

Verification (defaults STAGES=5, BR_STAGE=1, BR_SHADOW=1, EXCP_CYCLES=2)
REQ-031 redirect_i pulse 1 cycle, no stalls -> cycle N: flush_o=5'b00001, pc_invalid_o=1; N+1: flush_o=5'b00001, pc_invalid_o=0, state_o=1; N+2: flush_o=0, state_o=0.
REQ-032 stall_req_i=5'b00100 -> stall_o=5'b00111, flush_o=5'b01000; perf_stall_cnt_o +1 per cycle.
REQ-033 redirect_i with stall_req_i=5'b00010 -> stall_o=5'b00011, flush_o=5'b00100, pc_invalid_o=0, state stays IDLE.
REQ-034 excp_i pulse in SHADOW with stall_req_i=5'b11111 -> flush_o=5'b11111, stall_o=0 for 3 cycles (trigger + 2), then IDLE, stalls resume.
REQ-035 SHADOW entered then stall_req_i[0]=1 for 3 cycles -> state_o=1 held those 3 cycles, exits one unstalled cycle later; second redirect during SHADOW reloads counter.
REQ-036 Preload perf_stall_cnt_o near max (PERF_W=4: 14 stall cycles) then 3 more stall cycles -> holds 4'hF; rst_n pulse mid-EXCP -> all outputs 0, state_o=0.
